// File: rtl/i2c_pkg.sv
// Shared definitions for the I2C register slave: FSM states, bus ACK/NACK levels
// and the default 7-bit bus address.
`timescale 1ns/1ps
package i2c_pkg;

  typedef enum logic [3:0] {
    ST_IDLE,
    ST_ADDR,
    ST_ADDR_ACK,
    ST_REG,
    ST_REG_ACK,
    ST_WDATA,
    ST_WDATA_ACK,
    ST_RDATA,
    ST_RDATA_ACK,
    ST_IGNORE
  } i2c_state_t;

  localparam logic ACK  = 1'b0;
  localparam logic NACK = 1'b1;

  localparam logic [6:0] DEFAULT_SLAVE_ADDR = 7'b1101001;

endpackage

// File: rtl/i2c_sync_edge.sv
// Two-flop synchronizer for one asynchronous bus line, with single-clk rise/fall
// pulses derived from the synchronized value. Flops reset to 1 (idle bus level).
`timescale 1ns/1ps
module i2c_sync_edge (
  input  logic clk,
  input  logic rst_n,
  input  logic i_d,
  output logic o_q,
  output logic o_rise,
  output logic o_fall
);

  logic r_s1;
  logic r_s2;
  logic r_s3;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s1 <= 1'b1;
      r_s2 <= 1'b1;
      r_s3 <= 1'b1;
    end else begin
      r_s1 <= i_d;
      r_s2 <= r_s1;
      r_s3 <= r_s2;
    end
  end

  assign o_q    = r_s2;
  assign o_rise = r_s2 & ~r_s3;
  assign o_fall = ~r_s2 & r_s3;

endmodule

// File: rtl/i2c_slave_regs.sv
// I2C slave exposing a byte-wide register file: write = [addr+W][ptr][data...],
// read = [addr+R] then bytes from regs[ptr]. Define I2C_SLAVE_AUTOINC_EN to advance ptr per data byte.
`timescale 1ns/1ps
module i2c_slave_regs
  import i2c_pkg::*;
#(
  parameter logic [6:0]  SLAVE_ADDR = DEFAULT_SLAVE_ADDR,
  parameter int unsigned NUM_REGS   = 16
) (
  input  logic       clk,
  input  logic       reset,
  input  logic       scl,
  input  logic       SDA_in,
  output logic       sda_oe,
  output logic       busy,
  output logic       wr_strobe,
  output logic [7:0] wr_addr,
  output logic [7:0] wr_data
);

  localparam int unsigned AW = (NUM_REGS > 1) ? $clog2(NUM_REGS) : 1;

  logic w_scl;
  logic w_scl_rise;
  logic w_scl_fall;
  logic w_sda;
  logic w_sda_rise;
  logic w_sda_fall;

  i2c_sync_edge u_sync_scl (
    .clk    (clk),
    .rst_n  (reset),
    .i_d    (scl),
    .o_q    (w_scl),
    .o_rise (w_scl_rise),
    .o_fall (w_scl_fall)
  );

  i2c_sync_edge u_sync_sda (
    .clk    (clk),
    .rst_n  (reset),
    .i_d    (SDA_in),
    .o_q    (w_sda),
    .o_rise (w_sda_rise),
    .o_fall (w_sda_fall)
  );

  i2c_state_t r_state;
  logic [7:0] r_shift;
  logic [7:0] r_ptr;
  logic [2:0] r_bitcnt;
  logic       r_rw;
  logic       r_sda_oe;
  logic       r_busy;
  logic       r_wr_strobe;
  logic [7:0] r_wr_addr;
  logic [7:0] r_wr_data;
  logic [7:0] r_regs [NUM_REGS];

  logic       w_start;
  logic       w_stop;
  logic [7:0] w_byte;
  logic       w_last;
  logic       w_ptr_ok;
  logic [7:0] w_rd_byte;
  logic [7:0] w_ptr_next;
  logic       w_oe_fall;

  assign w_start   = w_sda_fall & w_scl;
  assign w_stop    = w_sda_rise & w_scl;
  assign w_byte    = {r_shift[6:0], w_sda};
  assign w_last    = (r_bitcnt == 3'd7);
  assign w_ptr_ok  = (32'(r_ptr) < NUM_REGS);
  assign w_rd_byte = w_ptr_ok ? r_regs[r_ptr[AW-1:0]] : 8'hFF;

`ifdef I2C_SLAVE_AUTOINC_EN
  assign w_ptr_next = r_ptr + 8'd1;
`else
  assign w_ptr_next = r_ptr;
`endif

  // SDA level to present after the next scl fall; the bit being read out sits in r_shift[7].
  always_comb begin
    w_oe_fall = 1'b0;
    case (r_state)
      ST_ADDR_ACK, ST_REG_ACK, ST_WDATA_ACK: w_oe_fall = 1'b1;
      ST_RDATA:                              w_oe_fall = ~r_shift[7];
      default:                               w_oe_fall = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      r_state     <= ST_IDLE;
      r_shift     <= '0;
      r_ptr       <= '0;
      r_bitcnt    <= '0;
      r_rw        <= 1'b0;
      r_sda_oe    <= 1'b0;
      r_busy      <= 1'b0;
      r_wr_strobe <= 1'b0;
      r_wr_addr   <= '0;
      r_wr_data   <= '0;
      for (int unsigned i = 0; i < NUM_REGS; i++) begin
        r_regs[i] <= '0;
      end
    end else begin
      r_wr_strobe <= 1'b0;
      // Bus conditions outrank any scl edge seen in the same clk.
      if (w_start) begin
        r_state  <= ST_ADDR;
        r_bitcnt <= '0;
        r_sda_oe <= 1'b0;
      end else if (w_stop) begin
        r_state  <= ST_IDLE;
        r_sda_oe <= 1'b0;
        r_busy   <= 1'b0;
      end else if (w_scl_rise) begin
        case (r_state)
          ST_ADDR: begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              if (w_byte[7:1] == SLAVE_ADDR) begin
                r_state <= ST_ADDR_ACK;
                r_rw    <= w_byte[0];
                r_busy  <= 1'b1;
              end else begin
                r_state <= ST_IGNORE;
              end
            end
          end
          ST_ADDR_ACK: begin
            r_bitcnt <= '0;
            if (r_rw) begin
              r_state <= ST_RDATA;
              r_shift <= w_rd_byte;
            end else begin
              r_state <= ST_REG;
            end
          end
          ST_REG: begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              r_ptr   <= w_byte;
              r_state <= ST_REG_ACK;
            end
          end
          ST_REG_ACK, ST_WDATA_ACK: begin
            r_bitcnt <= '0;
            r_state  <= ST_WDATA;
          end
          ST_WDATA: begin
            r_shift  <= w_byte;
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              if (w_ptr_ok) begin
                r_regs[r_ptr[AW-1:0]] <= w_byte;
                r_wr_strobe           <= 1'b1;
                r_wr_addr             <= r_ptr;
                r_wr_data             <= w_byte;
              end
              r_ptr   <= w_ptr_next;
              r_state <= ST_WDATA_ACK;
            end
          end
          ST_RDATA: begin
            r_shift  <= {r_shift[6:0], 1'b0};
            r_bitcnt <= r_bitcnt + 3'd1;
            if (w_last) begin
              r_ptr   <= w_ptr_next;
              r_state <= ST_RDATA_ACK;
            end
          end
          ST_RDATA_ACK: begin
            case (w_sda)
              ACK: begin
                r_state  <= ST_RDATA;
                r_bitcnt <= '0;
                r_shift  <= w_rd_byte;
              end
              NACK: r_state <= ST_IGNORE;
            endcase
          end
          default: r_state <= r_state;
        endcase
      end else if (w_scl_fall) begin
        r_sda_oe <= w_oe_fall;
      end
    end
  end

  assign sda_oe    = r_sda_oe;
  assign busy      = r_busy;
  assign wr_strobe = r_wr_strobe;
  assign wr_addr   = r_wr_addr;
  assign wr_data   = r_wr_data;

endmodule

// File: tb/tb_i2c_slave_regs.sv
// Directed bench for i2c_slave_regs: a bit-banging master, a transaction-level register
// model, and a per-cycle compare of sda_oe and write commits against that model.
`timescale 1ns/1ps
module tb_i2c_slave_regs;

  localparam int Q = 8;
`ifdef I2C_SLAVE_AUTOINC_EN
  localparam bit AUTOINC = 1'b1;
`else
  localparam bit AUTOINC = 1'b0;
`endif

  logic       clk = 1'b0;
  logic       reset = 1'b0;
  logic       scl = 1'b1;
  logic       m_sda = 1'b1;
  logic       w_line;
  logic       sda_oe;
  logic       busy;
  logic       wr_strobe;
  logic [7:0] wr_addr;
  logic [7:0] wr_data;

  assign w_line = m_sda & ~sda_oe;

  always #5 clk = ~clk;

  i2c_slave_regs #(
    .SLAVE_ADDR (7'h69),
    .NUM_REGS   (16)
  ) dut (
    .clk       (clk),
    .reset     (reset),
    .scl       (scl),
    .SDA_in    (w_line),
    .sda_oe    (sda_oe),
    .busy      (busy),
    .wr_strobe (wr_strobe),
    .wr_addr   (wr_addr),
    .wr_data   (wr_data)
  );

  int checks = 0;
  int failures = 0;
  int strobe_cnt = 0;

  logic exp_valid = 1'b0;
  logic exp_oe = 1'b0;

  typedef struct packed {
    logic [7:0] a;
    logic [7:0] d;
  } wr_t;

  logic [7:0] m_regs [16];
  logic [7:0] m_ptr;
  wr_t        exp_q[$];

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%0h required=%0h at %0t", nm, act, exp, $time);
    end
  endtask

  task automatic m_reset();
    for (int i = 0; i < 16; i++) m_regs[i] = 8'h00;
    m_ptr = 8'h00;
    exp_q.delete();
  endtask

  task automatic m_write(input logic [7:0] b);
    if (m_ptr < 8'd16) begin
      m_regs[m_ptr[3:0]] = b;
      exp_q.push_back('{a: m_ptr, d: b});
    end
    if (AUTOINC) m_ptr = m_ptr + 8'd1;
  endtask

  task automatic m_read(output logic [7:0] r);
    r = (m_ptr < 8'd16) ? m_regs[m_ptr[3:0]] : 8'hFF;
    if (AUTOINC) m_ptr = m_ptr + 8'd1;
  endtask

  always @(negedge clk) begin
    if (exp_valid) chk("sda_oe", sda_oe, exp_oe);
    if (wr_strobe) begin
      strobe_cnt++;
      if (exp_q.size() == 0) begin
        checks++;
        failures++;
        $display("FAIL wr_strobe_unexpected actual addr=%0h data=%0h required=no strobe", wr_addr, wr_data);
      end else begin
        wr_t e;
        e = exp_q.pop_front();
        chk("wr_addr_commit", wr_addr, e.a);
        chk("wr_data_commit", wr_data, e.d);
      end
    end
  end

  task automatic wclk(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  // One scl period starting and ending with scl low; s is the line seen mid-high.
  task automatic bit_clock(input logic b, input logic e_oe, output logic s);
    m_sda = b;
    wclk(Q);
    scl = 1'b1;
    exp_oe = e_oe;
    exp_valid = 1'b1;
    wclk(Q);
    s = w_line;
    wclk(Q);
    exp_valid = 1'b0;
    scl = 1'b0;
    wclk(Q);
  endtask

  task automatic do_start();
    m_sda = 1'b1;
    wclk(Q);
    scl = 1'b1;
    wclk(Q);
    m_sda = 1'b0;
    wclk(Q);
    scl = 1'b0;
    wclk(Q);
  endtask

  task automatic do_stop();
    m_sda = 1'b0;
    wclk(Q);
    scl = 1'b1;
    wclk(Q);
    m_sda = 1'b1;
    wclk(2 * Q);
  endtask

  task automatic send_byte(input logic [7:0] b, input logic exp_ack, input string nm);
    logic s;
    for (int i = 7; i >= 0; i--) bit_clock(b[i], 1'b0, s);
    bit_clock(1'b1, exp_ack, s);
    chk(nm, s, !exp_ack);
  endtask

  task automatic read_byte(input logic [7:0] e, input logic mack, output logic [7:0] g);
    logic s;
    for (int i = 7; i >= 0; i--) begin
      bit_clock(1'b1, !e[i], s);
      g[i] = s;
    end
    bit_clock(mack, 1'b0, s);
  endtask

  task automatic set_reg(input logic [7:0] r);
    do_start();
    send_byte(8'hD2, 1'b1, "ack_addr_w");
    m_ptr = r;
    send_byte(r, 1'b1, "ack_reg");
  endtask

  task automatic write_data(input logic [7:0] b);
    m_write(b);
    send_byte(b, 1'b1, "ack_wdata");
  endtask

  task automatic read_one(input logic mack, output logic [7:0] e, output logic [7:0] g);
    m_read(e);
    read_byte(e, mack, g);
  endtask

  task automatic read_reg(input logic [7:0] r, input logic [7:0] lit, input string nm);
    logic [7:0] e, g;
    set_reg(r);
    do_start();
    send_byte(8'hD3, 1'b1, "ack_addr_r");
    read_one(1'b1, e, g);
    chk({nm, "_model"}, e, lit);
    chk(nm, g, e);
    do_stop();
  endtask

  initial begin
    logic [7:0] e1, g1, e2, g2;
    logic s;
    m_reset();

    wclk(5);
    chk("rst_sda_oe", sda_oe, 1'b0);
    chk("rst_busy", busy, 1'b0);
    chk("rst_wr_strobe", wr_strobe, 1'b0);
    chk("rst_wr_addr", wr_addr, 8'h00);
    chk("rst_wr_data", wr_data, 8'h00);
    reset = 1'b1;
    wclk(5);

    // Basic write of one byte
    set_reg(8'h03);
    chk("busy_after_match", busy, 1'b1);
    write_data(8'hA5);
    do_stop();
    chk("busy_after_stop", busy, 1'b0);
    chk("wr_addr_lit", wr_addr, 8'h03);
    chk("wr_data_lit", wr_data, 8'hA5);
    chk("strobe_cnt_write", strobe_cnt, 1);

    // Pointer write, repeated START, single-byte read with NACK
    read_reg(8'h03, 8'hA5, "read_a5");
    chk("sda_oe_after_nack", sda_oe, 1'b0);

    // Foreign address
    do_start();
    send_byte(8'hA0, 1'b0, "nack_foreign");
    send_byte(8'h55, 1'b0, "nack_foreign_data");
    chk("busy_foreign", busy, 1'b0);
    do_stop();
    chk("strobe_cnt_foreign", strobe_cnt, 1);

    // Two data bytes at the top register
    set_reg(8'h0F);
    write_data(8'h11);
    write_data(8'h22);
    do_stop();
    set_reg(8'h0F);
    do_start();
    send_byte(8'hD3, 1'b1, "ack_addr_r");
    read_one(1'b0, e1, g1);
    read_one(1'b1, e2, g2);
    do_stop();
    chk("r15_first_model", e1, AUTOINC ? 8'h11 : 8'h22);
    chk("r15_first", g1, e1);
    chk("r15_second_model", e2, AUTOINC ? 8'hFF : 8'h22);
    chk("r15_second", g2, e2);

    // Out-of-range pointer: write dropped, read returns FF
    set_reg(8'h80);
    write_data(8'h77);
    do_stop();
    read_reg(8'h80, 8'hFF, "read_oob");

    // Partial byte aborted by STOP
    set_reg(8'h05);
    write_data(8'h3C);
    do_stop();
    set_reg(8'h05);
    for (int i = 0; i < 4; i++) bit_clock(1'b1, 1'b0, s);
    do_stop();
    read_reg(8'h05, 8'h3C, "read_partial");
    chk("strobe_cnt_partial", strobe_cnt, AUTOINC ? 3 : 4);

    // Reset asserted while the slave drives ACK
    do_start();
    for (int i = 7; i >= 0; i--) bit_clock(s_d2(i), 1'b0, s);
    m_sda = 1'b1;
    wclk(Q);
    scl = 1'b1;
    wclk(2);
    chk("ack_before_reset", sda_oe, 1'b1);
    reset = 1'b0;
    #1;
    chk("sda_oe_async_reset", sda_oe, 1'b0);
    chk("busy_async_reset", busy, 1'b0);
    wclk(3);
    chk("wr_addr_reset", wr_addr, 8'h00);
    chk("wr_data_reset", wr_data, 8'h00);
    m_reset();
    reset = 1'b1;
    wclk(Q);
    read_reg(8'h03, 8'h00, "read_r3_cleared");
    read_reg(8'h05, 8'h00, "read_r5_cleared");

    wclk(4);
    chk("pending_strobes", exp_q.size(), 0);
    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

  function automatic logic s_d2(input int i);
    logic [7:0] v;
    v = 8'hD2;
    return v[i];
  endfunction

  initial begin
    #5ms;
    $display("FAIL timeout actual=running required=finished");
    $fatal(1);
  end

endmodule

// File: doc/i2c_slave_regs.md
I2C_SLAVE_REGS -- requirements
Module: i2c_slave_regs

Interface
REQ-001 The block SHALL have parameter SLAVE_ADDR, default 7'b1101001, the 7-bit bus address it responds to.
REQ-002 The block SHALL have parameter NUM_REGS, default 16, the register file depth in bytes (power of two, 2..256).
REQ-003 The block SHALL have port clk, input, 1 bit, the single system clock; all logic runs on its rising edge.
REQ-004 The block SHALL have port reset, input, 1 bit, an asynchronous active-low reset.
REQ-005 The block SHALL have port scl, input, 1 bit, the bus clock from the master (asynchronous to clk).
REQ-006 The block SHALL have port SDA_in, input, 1 bit, the sampled bus data line.
REQ-007 The block SHALL have port sda_oe, output, 1 bit; when 1 it pulls SDA low, and when 0 it releases SDA.
REQ-008 The block SHALL have port busy, output, 1 bit; it is 1 from an address-matched START to the next STOP.
REQ-009 The block SHALL have port wr_strobe, output, 1 bit, a one-clk pulse when a data byte is committed to the register file.
REQ-010 The block SHALL have port wr_addr, output, 8 bits, the register index of the last commit.
REQ-011 The block SHALL have port wr_data, output, 8 bits, the byte of the last commit.

Function
REQ-012 scl and SDA_in SHALL pass through 2-flop synchronizers; rise and fall edges are detected from the synchronized values (2-3 clk latency).
REQ-013 START SHALL be detected as an SDA fall while scl is high, and STOP as an SDA rise while scl is high; both are honoured in every state, including a repeated START.
REQ-014 States SHALL be IDLE, ADDR, ADDR_ACK, REG, REG_ACK, WDATA, WDATA_ACK, RDATA, RDATA_ACK and IGNORE.
REQ-015 START SHALL go to ADDR with the bit counter cleared; STOP SHALL go to IDLE and release sda_oe within 1 clk.
REQ-016 Bits SHALL be sampled on the scl rise edge, MSB first; sda_oe changes only one clk after an scl fall edge.
REQ-017 ADDR SHALL take 8 bits (7 address bits plus R/W); on a match it goes to ADDR_ACK and drives ACK (sda_oe=1) for one scl period; on a mismatch it goes to IGNORE with sda_oe=0 until START or STOP.
REQ-018 After ADDR_ACK, W SHALL go to REG and R SHALL go to RDATA, which shifts out regs[ptr].
REQ-019 REG SHALL load ptr with the received byte, ACK it, and then go to WDATA.
REQ-020 WDATA SHALL receive a byte, and on the 8th scl rise SHALL pulse wr_strobe, write regs[ptr] (when ptr<NUM_REGS) and ACK; it accepts further bytes until STOP or START.
REQ-021 In RDATA the block SHALL drive sda_oe = ~bit, and in RDATA_ACK it SHALL sample the master's ACK: ACK (0) continues with the next byte; NACK (1) goes to IGNORE.
REQ-022 ptr>=NUM_REGS SHALL still be ACKed; writes are dropped (no wr_strobe) and reads return 8'hFF.
REQ-023 A START or STOP mid-byte SHALL discard the partial byte with no register change.
REQ-024 When a START and an scl edge are recognised in the same clk, the START SHALL take priority.

Reset
REQ-025 While reset=0 the block SHALL be in IDLE, with sda_oe=0, busy=0, wr_strobe=0, wr_addr=0, wr_data=0, ptr=0, all regs=8'h00 and synchronizers=1.
REQ-026 Reset asserted mid-transfer SHALL release SDA immediately (asynchronously).

Configuration
REQ-027 With I2C_SLAVE_AUTOINC_EN defined, ptr SHALL increment after each written or read data byte, wrapping 8'hFF->8'h00.
REQ-028 Without I2C_SLAVE_AUTOINC_EN, ptr SHALL stay fixed, so every byte of the transaction targets the same register.

Structure
REQ-029 The package i2c_pkg SHALL hold the state enum, ACK=1'b0 and NACK=1'b1, and the default SLAVE_ADDR.
REQ-030 The sub-module i2c_sync_edge SHALL contain one 2-flop synchronizer with rise and fall pulses, instantiated for scl and SDA.

Verification
REQ-031 Write 0xD2, 0x03, 0xA5, then STOP -> 3 ACKs, one wr_strobe with wr_addr=0x03 and wr_data=0xA5, then busy=0.
REQ-032 Write 0xD2, 0x03, then repeated START and 0xD3, then read one byte and NACK -> SDA carries 0xA5 and sda_oe=0 after the NACK.
REQ-033 Address 0xA0 -> no ACK, sda_oe=0 throughout, and no wr_strobe.
REQ-034 Write 0xD2, 0x0F, 0x11, 0x22 -> with AUTOINC: regs[15]=0x11 and 0x22 dropped (ptr=16); without it: regs[15]=0x22.
REQ-035 Reset low during the ACK bit -> sda_oe=0 within 1 clk, state IDLE, and regs cleared.
REQ-036 STOP after 4 data bits -> no wr_strobe and the register unchanged.
